instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
Consumer end of the program-counter interface. It accepts a fetch address from the instruction address generator and issues one word read to instruction memory over a req/ack handshake. Each returned word is stored, with its address, in a small first-word-fall-through prefetch queue that feeds decode. It back-pressures the address generator through PC_Stall and discards stale fetches on a Flush (branch or return redirect).

Parameters:
DEPTH, 4, prefetch queue entries; power of two, minimum 2
CNT_W, 16, width of the delivered-instruction counter

Ports:
Clock  input  1  single system clock, rising-edge
Reset  input  1  asynchronous, active-high; clears all state
PC  input  32  fetch address (word address)
PC_Valid  input  1  PC holds a new fetch address this cycle
PC_Stall  output  1  fetch not accepted; address generator must hold PC_enable low
Flush  input  1  redirect: discard queued and in-flight instructions
Mem_Req  output  1  read request to instruction memory
Mem_Addr  output  32  read address, stable while Mem_Req high
Mem_Ack  input  1  Mem_Data valid this cycle; completes the request
Mem_Data  input  32  instruction word from memory
IR  output  32  head-of-queue instruction
IR_PC  output  32  address of IR (goes to PC_temp / return-address path)
IR_Valid  output  1  queue non-empty
IR_Ready  input  1  decode consumes head entry when IR_Valid & IR_Ready
Fetch_Count  output  CNT_W  number of instructions delivered to decode

Behaviour:
- Clock/reset: one clock, Clock. Reset is asynchronous and active-high.
- Reset (async, any cycle, including mid-request):
  - State to IDLE; Mem_Req=0, Mem_Addr=0.
  - Queue emptied (pointers and count 0); IR_Valid=0, IR=0, IR_PC=0.
  - Fetch_Count=0.
  - Memory must tolerate a request dropped by reset.
- PC_Stall (combinational) = Flush | (state!=IDLE) | (count==DEPTH).
- FSM states: IDLE, REQ, DRAIN.
  - IDLE: PC_Valid & ~PC_Stall accepts a fetch. Mem_Addr<=PC, Mem_Req<=1, go to REQ. Mem_Req rises the cycle after acceptance.
  - REQ: Mem_Req and Mem_Addr held until Mem_Ack.
    - Mem_Ack & ~Flush: push {Mem_Data, Mem_Addr}, Mem_Req<=0, go to IDLE.
    - Mem_Ack & Flush: data discarded, go to IDLE.
    - ~Mem_Ack & Flush: go to DRAIN.
  - DRAIN: Mem_Req held until Mem_Ack; returned data discarded; then IDLE. A Flush in DRAIN has no further effect.
- At most one request outstanding. Minimum accept-to-IR_Valid latency is 2 cycles with a zero-wait memory (Ack in the first Req cycle).
- Queue:
  - First-word-fall-through. IR/IR_PC show the head entry whenever IR_Valid=1, and hold their last value when empty.
  - Pop on IR_Valid & IR_Ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Overflow is impossible because acceptance requires count<DEPTH and count cannot grow before the ack.
  - Pointers wrap modulo DEPTH.
- Flush (synchronous): queue emptied that edge, so IR_Valid=0 next cycle. A pop in the same cycle is ignored and not counted. Flush overrides both push and pop.
- Fetch_Count increments by 1 per pop and wraps from 2^CNT_W-1 to 0.
- Mem_Data is not checked or decoded.

Test Plan:
1. Reset, then PC=0x10 with PC_Valid=1, memory acks one cycle after Mem_Req with 0xDEADBEEF, IR_Ready=1 -> Mem_Addr=0x10; one cycle later IR=0xDEADBEEF, IR_PC=0x10, IR_Valid=1; Fetch_Count=1 after the pop.
2. IR_Ready=0, sequential PCs 0x0..0x5 -> four entries queued, then PC_Stall=1 with count=4 and no Mem_Req. Raise IR_Ready -> words pop in order with IR_PC 0x0,0x1,0x2,0x3, then fetch resumes at 0x4.
3. Flush while in REQ with Mem_Ack delayed 3 cycles, two entries queued -> IR_Valid=0 next cycle; Mem_Req stays high until ack; acked word is not queued; PC_Stall low again the cycle after the ack.
4. Flush in the same cycle as Mem_Ack and IR_Ready, one entry queued -> queue empty, nothing pushed, Fetch_Count unchanged.
5. Assert Reset mid-REQ with 3 entries queued -> Mem_Req, IR_Valid and Fetch_Count are 0 immediately, without waiting for a clock edge; after release, a fetch of 0x40 proceeds normally.
6. CNT_W=4: deliver 17 instructions -> Fetch_Count reads 1; simultaneous push/pop at count=DEPTH-1 holds count stable across 8 cycles.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: accepts a fetch address, issues one memory read per fetch
// and queues returned words with their addresses for decode.
module instruction_fetch_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [31:0]      PC,
    input  logic             PC_Valid,
    output logic             PC_Stall,
    input  logic             Flush,
    output logic             Mem_Req,
    output logic [31:0]      Mem_Addr,
    input  logic             Mem_Ack,
    input  logic [31:0]      Mem_Data,
    output logic [31:0]      IR,
    output logic [31:0]      IR_PC,
    output logic             IR_Valid,
    input  logic             IR_Ready,
    output logic [CNT_W-1:0] Fetch_Count
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetchState_t;

    fetchState_t      state, nextState;
    logic [31:0]      addrReg;
    logic [31:0]      dataMem [DEPTH];
    logic [31:0]      pcMem   [DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [PTR_W:0]   count;
    logic [31:0]      holdIr, holdPc;
    logic [CNT_W-1:0] fetchCount;
    logic             accept, push, pop, queueEmpty, queueFull;

    assign queueEmpty = (count == '0);
    assign queueFull  = (count == (PTR_W+1)'(DEPTH));
    assign PC_Stall   = Flush | (state != IDLE) | queueFull;
    assign accept     = PC_Valid & ~PC_Stall;
    // A flush discards the returning word and overrides any pop by decode.
    assign push       = (state == REQ) & Mem_Ack & ~Flush;
    assign pop        = ~queueEmpty & IR_Ready & ~Flush;

    assign Mem_Req     = (state != IDLE);
    assign Mem_Addr    = addrReg;
    assign IR_Valid    = ~queueEmpty;
    assign IR          = queueEmpty ? holdIr : dataMem[rdPtr];
    assign IR_PC       = queueEmpty ? holdPc : pcMem[rdPtr];
    assign Fetch_Count = fetchCount;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    // DRAIN keeps the request up until memory answers, since it cannot be withdrawn.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = REQ;
            REQ: begin
                if (Mem_Ack)    nextState = IDLE;
                else if (Flush) nextState = DRAIN;
            end
            DRAIN:   if (Mem_Ack) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)       addrReg <= '0;
        else if (accept) addrReg <= PC;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (Flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            dataMem[wrPtr] <= Mem_Data;
            pcMem[wrPtr]   <= addrReg;
        end
    end

    // Snapshot of the head so IR/IR_PC keep their last value once the queue drains.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            holdIr <= '0;
            holdPc <= '0;
        end else if (!queueEmpty) begin
            holdIr <= dataMem[rdPtr];
            holdPc <= pcMem[rdPtr];
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)    fetchCount <= '0;
        else if (pop) fetchCount <= fetchCount + 1'b1;
    end

endmodule
